// File: rtl/flux_capture.sv
// Flux front end: synchronises drive read/index lines, times falling-edge intervals and queues flux words.
// Optional glitch filter enabled with `define FLUX_GLITCH_FILTER_EN (rejects intervals below MIN_INTERVAL).
module flux_capture #(
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_INTERVAL = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdata_n,
  input  logic                          index_n,
  input  logic                          capture_en,
  output logic [15:0]                   flux_data,
  output logic                          flux_valid,
  input  logic                          flux_ready,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [14:0] LP_CNT_MAX = 15'h7FFF;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (MIN_INTERVAL < 1 || MIN_INTERVAL > 32767) begin : g_bad_min
    $error("MIN_INTERVAL must be in 1..32767");
  end

  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic [SYNC_STAGES-1:0] r_ix_sync;
  logic                   r_rd_hist;
  logic                   r_ix_hist;
  logic [14:0]            r_cnt;
  logic                   r_idx_pending;
  logic [15:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_overflow;

  logic        w_rd_edge;
  logic        w_ix_edge;
  logic [14:0] w_e;
  logic        w_accept;
  logic        w_push;
  logic [15:0] w_word;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;
  logic        w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_sync <= '1;
      r_ix_sync <= '1;
      r_rd_hist <= 1'b1;
      r_ix_hist <= 1'b1;
    end else begin
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], rdata_n};
      r_ix_sync <= {r_ix_sync[SYNC_STAGES-2:0], index_n};
      r_rd_hist <= r_rd_sync[SYNC_STAGES-1];
      r_ix_hist <= r_ix_sync[SYNC_STAGES-1];
    end
  end

  assign w_rd_edge = r_rd_hist & ~r_rd_sync[SYNC_STAGES-1];
  assign w_ix_edge = r_ix_hist & ~r_ix_sync[SYNC_STAGES-1];
  assign w_e       = r_cnt + 15'd1;

`ifdef FLUX_GLITCH_FILTER_EN
  assign w_accept = w_rd_edge & (w_e >= 15'(MIN_INTERVAL));
`else
  assign w_accept = w_rd_edge;
`endif

  // A rejected edge falls through to the marker/count path, so counting continues.
  assign w_push = capture_en & (w_accept | (w_e == LP_CNT_MAX));
  assign w_word = {r_idx_pending | w_ix_edge, w_accept ? w_e : 15'd0};

  always_ff @(posedge clk) begin
    if (rst || !capture_en) begin
      r_cnt         <= '0;
      r_idx_pending <= 1'b0;
    end else begin
      r_cnt <= w_push ? 15'd0 : w_e;
      if (w_push) begin
        r_idx_pending <= 1'b0;
      end else if (w_ix_edge) begin
        r_idx_pending <= 1'b1;
      end
    end
  end

  assign flux_valid = (r_count != '0);
  assign w_full     = (r_count == LP_DEPTH);
  assign w_pop      = flux_valid & flux_ready;
  assign w_wr       = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign flux_data  = flux_valid ? r_mem[r_rd_ptr] : '0;
  assign overflow   = r_overflow;
  assign fifo_level = r_count;

endmodule

// File: tb/tb_flux_capture.sv
// Self-checking bench for flux_capture: cycle-level reference model plus directed literal checks and random stimulus.
module tb_flux_capture;

  localparam int D    = 16;
  localparam int S    = 2;
  localparam int MINI = 8;
`ifdef FLUX_GLITCH_FILTER_EN
  localparam int THR  = MINI;
`else
  localparam int THR  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdata_n = 1'b1;
  logic        index_n = 1'b1;
  logic        capture_en = 1'b1;
  logic        flux_ready = 1'b1;
  logic        overflow_clr = 1'b0;
  logic [15:0] flux_data;
  logic        flux_valid;
  logic        overflow;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  flux_capture #(
    .FIFO_DEPTH  (D),
    .SYNC_STAGES (S),
    .MIN_INTERVAL(MINI)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdata_n     (rdata_n),
    .index_n     (index_n),
    .capture_en  (capture_en),
    .flux_data   (flux_data),
    .flux_valid  (flux_valid),
    .flux_ready  (flux_ready),
    .overflow    (overflow),
    .overflow_clr(overflow_clr),
    .fifo_level  (fifo_level)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs seen S cycles late, intervals as absolute time since last reference point.
  longint      cyc = 0;
  longint      t_ref = 0;
  logic [15:0] q[$];
  logic [15:0] log_q[$];
  bit          m_ovf = 0;
  bit          m_pend = 0;
  bit          sh_rd[S+1];
  bit          sh_ix[S+1];

  initial begin
    for (int i = 0; i <= S; i++) begin
      sh_rd[i] = 1;
      sh_ix[i] = 1;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        m_ovf  = 0;
        m_pend = 0;
        t_ref  = cyc;
        for (int i = 0; i <= S; i++) begin
          sh_rd[i] = 1;
          sh_ix[i] = 1;
        end
      end else begin
        bit          rd_e, ix_e, pop, pushed, set;
        longint      e;
        logic [15:0] word;
        rd_e = sh_rd[S] && !sh_rd[S-1];
        ix_e = sh_ix[S] && !sh_ix[S-1];
        for (int i = S; i > 0; i--) begin
          sh_rd[i] = sh_rd[i-1];
          sh_ix[i] = sh_ix[i-1];
        end
        sh_rd[0] = rdata_n;
        sh_ix[0] = index_n;
        pop    = (q.size() != 0) && flux_ready;
        pushed = 0;
        word   = '0;
        if (capture_en) begin
          e = cyc - t_ref;
          if (rd_e && e >= THR) begin
            word   = {m_pend | ix_e, 15'(e)};
            pushed = 1;
          end else if (e == 32767) begin
            word   = {m_pend | ix_e, 15'd0};
            pushed = 1;
          end
          if (pushed) begin
            t_ref  = cyc;
            m_pend = 0;
          end else if (ix_e) begin
            m_pend = 1;
          end
        end else begin
          t_ref  = cyc;
          m_pend = 0;
        end
        if (pop) void'(q.pop_front());
        set = 0;
        if (pushed) begin
          log_q.push_back(word);
          if (q.size() < D) q.push_back(word);
          else set = 1;
        end
        if (set) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("valid", flux_valid, q.size() != 0);
        chk("data", flux_data, (q.size() != 0) ? q[0] : 16'h0);
        chk("overflow", overflow, m_ovf);
        chk("level", fifo_level, q.size());
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic edge_gap(input int d);
    rdata_n = 1'b0;
    tick(1);
    rdata_n = 1'b1;
    tick(d - 1);
  endtask

  initial begin
    // Reset held while inputs toggle.
    for (int i = 0; i < 20; i++) begin
      rdata_n = i[0];
      index_n = i[1];
      tick(1);
    end
    rdata_n = 1'b1;
    index_n = 1'b1;
    chk_on  = 1;
    tick(2);
    chk("rst_valid", flux_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // First edge 100 cycles after reset, with SYNC_STAGES latency check.
    tick(97);
    rdata_n = 1'b0;
    tick(1);
    rdata_n = 1'b1;
    chk("lat0_valid", flux_valid, 0);
    tick(1);
    chk("lat1_valid", flux_valid, 0);
    tick(1);
    chk("lat2_valid", flux_valid, 1);
    chk("lat2_data", flux_data, 16'h0064);
    chk("first_word", log_q[0], 16'h0064);
    tick(97);

    log_q.delete();
    repeat (4) edge_gap(100);
    chk("steady100_n", log_q.size(), 4);
    foreach (log_q[i]) chk("steady100", log_q[i], 16'h0064);

    log_q.delete();
    repeat (3) edge_gap(200);
    chk("steady200_n", log_q.size(), 3);
    chk("steady200_0", log_q[0], 16'h0064);
    chk("steady200_1", log_q[1], 16'h00C8);
    chk("steady200_2", log_q[2], 16'h00C8);

    // Glitch filter: edges at t, t+100, t+103, t+153.
    edge_gap(100);
    log_q.delete();
    edge_gap(3);
    edge_gap(50);
    edge_gap(100);
`ifdef FLUX_GLITCH_FILTER_EN
    chk("glitch_n", log_q.size(), 2);
    chk("glitch_0", log_q[0], 16'h0064);
    chk("glitch_1", log_q[1], 16'h0035);
`else
    chk("glitch_n", log_q.size(), 3);
    chk("glitch_0", log_q[0], 16'h0064);
    chk("glitch_1", log_q[1], 16'h0003);
    chk("glitch_2", log_q[2], 16'h0032);
`endif

    // Long gap of 70000 cycles.
    rdata_n = 1'b0;
    tick(1);
    rdata_n = 1'b1;
    tick(4);
    log_q.delete();
    tick(70000 - 5);
    edge_gap(100);
    chk("gap_n", log_q.size(), 3);
    chk("gap_0", log_q[0], 16'h0000);
    chk("gap_1", log_q[1], 16'h0000);
    chk("gap_2", log_q[2], 16'h1172);

    // Index pulse between two edges.
    rdata_n = 1'b0;
    tick(1);
    rdata_n = 1'b1;
    tick(49);
    index_n = 1'b0;
    tick(1);
    index_n = 1'b1;
    tick(49);
    log_q.delete();
    edge_gap(100);
    edge_gap(100);
    chk("idx_n", log_q.size(), 2);
    chk("idx_0", log_q[0], 16'h8064);
    chk("idx_1", log_q[1], 16'h0064);

    // Index while disabled is not reported.
    capture_en = 1'b0;
    tick(5);
    index_n = 1'b0;
    tick(1);
    index_n = 1'b1;
    tick(6);
    capture_en = 1'b1;
    log_q.delete();
    edge_gap(100);
    edge_gap(100);
    chk("idxdis_n", log_q.size(), 2);
    chk("idxdis_0_flag", log_q[0][15], 0);
    chk("idxdis_1", log_q[1], 16'h0064);

    // Full FIFO with consumer stalled.
    flux_ready = 1'b0;
    log_q.delete();
    repeat (17) edge_gap(20);
    chk("full_level", fifo_level, 16);
    chk("full_ovf", overflow, 1);
    chk("full_logn", log_q.size(), 17);
    for (int i = 1; i < 16; i++) chk("full_word", log_q[i], 16'h0014);
    chk("full_head", flux_data, log_q[0]);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    flux_ready = 1'b1;
    tick(20);
    chk("drained", fifo_level, 0);

    // Push and pop in the same cycle while full.
    flux_ready = 1'b0;
    repeat (16) edge_gap(20);
    chk("refill_level", fifo_level, 16);
    rdata_n = 1'b0;
    tick(1);
    rdata_n = 1'b1;
    tick(1);
    flux_ready = 1'b1;
    tick(1);
    flux_ready = 1'b0;
    chk("pp_level", fifo_level, 16);
    chk("pp_ovf", overflow, 0);
    flux_ready = 1'b1;
    tick(20);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rdata_n = ($urandom_range(0, 24) != 0);
      index_n = ($urandom_range(0, 199) != 0);
      if (c >= 1000 && c < 1600) flux_ready = ($urandom_range(0, 99) == 0);
      else flux_ready = ($urandom_range(0, 3) != 0);
      overflow_clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) capture_en = ~capture_en;
      rst = ($urandom_range(0, 1499) == 0);
      tick(1);
    end
    rst          = 1'b0;
    rdata_n      = 1'b1;
    index_n      = 1'b1;
    capture_en   = 1'b1;
    flux_ready   = 1'b1;
    overflow_clr = 1'b0;
    tick(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
